// File: rtl/execute_memory.sv
// EX/MEM stage: ALU, branch target and destination select feeding the EM pipeline
// register, plus an iterative shift-add multiplier that stalls upstream while busy.
module execute_memory #(
  parameter int DATA_W = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DE_Valid,
  input  logic [3:0]        DE_ALUCtrl,
  input  logic [DATA_W-1:0] DE_ReadData1,
  input  logic [DATA_W-1:0] DE_ReadData2,
  input  logic [DATA_W-1:0] DE_SignExt,
  input  logic              DE_ALUSrc,
  input  logic              DE_RegDst,
  input  logic [4:0]        DE_Rt,
  input  logic [4:0]        DE_Rd,
  input  logic [DATA_W-1:0] DE_PC4,
  input  logic              DE_MemRead,
  input  logic              DE_MemWrite,
  input  logic              DE_Branch,
  input  logic              DE_MemtoReg,
  input  logic              DE_RegWrite,
  input  logic [31:0]       DE_Instruction,
  output logic              Stall,
  output logic              EM_MemRead,
  output logic              EM_MemWrite,
  output logic              EM_Branch,
  output logic              EM_MemtoReg,
  output logic              EM_RegWrite,
  output logic              EM_ZERO,
  output logic [DATA_W-1:0] EM_Result,
  output logic [DATA_W-1:0] EM_Readdata2,
  output logic [4:0]        EM_Rd,
  output logic [DATA_W-1:0] EM_BranchTarget,
  output logic [31:0]       EM_Instruction,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

  state_t             state, state_next;
  logic [DATA_W-1:0]  op_b, alu_result, em_result_d;
  logic [DATA_W-1:0]  mcand, mplier, acc;
  logic [CNT_W-1:0]   count;
  logic               is_mul, stall_c, em_load, mul_start;

  assign op_b   = DE_ALUSrc ? DE_SignExt : DE_ReadData2;
  assign is_mul = MUL_EN && DE_Valid && (DE_ALUCtrl == ALU_MUL);

  always_comb begin
    alu_result = '0;
    case (DE_ALUCtrl)
      ALU_AND: alu_result = DE_ReadData1 & op_b;
      ALU_OR:  alu_result = DE_ReadData1 | op_b;
      ALU_ADD: alu_result = DE_ReadData1 + op_b;
      ALU_SUB: alu_result = DE_ReadData1 - op_b;
      ALU_SLT: alu_result = ($signed(DE_ReadData1) < $signed(op_b)) ?
                            {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      ALU_NOR: alu_result = ~(DE_ReadData1 | op_b);
      default: alu_result = '0;
    endcase
  end

  // Handshake: DE_Valid marks a real instruction in ID/EX. While Stall is high the
  // upstream stages hold every DE_* input stable; the instruction is consumed on the
  // first rising edge at which DE_Valid=1 and Stall=0 (MUL_DONE re-samples the held op).
  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    em_load    = 1'b0;
    mul_start  = 1'b0;
    case (state)
      IDLE: begin
        if (is_mul) begin
          stall_c    = 1'b1;
          mul_start  = 1'b1;
          state_next = MUL_BUSY;
        end else begin
          em_load = DE_Valid;
        end
      end
      MUL_BUSY: begin
        stall_c = 1'b1;
        if (count == CNT_W'(DATA_W-1)) state_next = MUL_DONE;
      end
      MUL_DONE: begin
        em_load    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gated with reset so a MUL held at the inputs cannot raise Stall during reset.
  assign Stall       = stall_c & rst;
  assign dbg_state   = state;
  assign em_result_d = (state == MUL_DONE) ? acc : alu_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (mul_start) begin
      mcand  <= DE_ReadData1;
      mplier <= op_b;
      acc    <= '0;
      count  <= '0;
    end else if (state == MUL_BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  // Anything that is not a completed instruction loads an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      EM_MemRead      <= 1'b0;
      EM_MemWrite     <= 1'b0;
      EM_Branch       <= 1'b0;
      EM_MemtoReg     <= 1'b0;
      EM_RegWrite     <= 1'b0;
      EM_ZERO         <= 1'b0;
      EM_Result       <= '0;
      EM_Readdata2    <= '0;
      EM_Rd           <= '0;
      EM_BranchTarget <= '0;
      EM_Instruction  <= '0;
    end else if (em_load) begin
      EM_MemRead      <= DE_MemRead;
      EM_MemWrite     <= DE_MemWrite;
      EM_Branch       <= DE_Branch;
      EM_MemtoReg     <= DE_MemtoReg;
      EM_RegWrite     <= DE_RegWrite;
      EM_ZERO         <= (em_result_d == '0);
      EM_Result       <= em_result_d;
      EM_Readdata2    <= DE_ReadData2;
      EM_Rd           <= DE_RegDst ? DE_Rd : DE_Rt;
      EM_BranchTarget <= DE_PC4 + {DE_SignExt[DATA_W-3:0], 2'b00};
      EM_Instruction  <= DE_Instruction;
    end else begin
      EM_MemRead      <= 1'b0;
      EM_MemWrite     <= 1'b0;
      EM_Branch       <= 1'b0;
      EM_MemtoReg     <= 1'b0;
      EM_RegWrite     <= 1'b0;
      EM_ZERO         <= 1'b0;
      EM_Result       <= '0;
      EM_Readdata2    <= '0;
      EM_Rd           <= '0;
      EM_BranchTarget <= '0;
      EM_Instruction  <= '0;
    end
  end

endmodule

// File: tb/tb_execute_memory.sv
// Bench for execute_memory: directed pipeline cases plus randomized ALU and MUL
// traffic compared against an arithmetic model of the EX/MEM register contents.
module tb_execute_memory;

  localparam int EM_W = 5 + 1 + 32 + 32 + 5 + 32 + 32;

  logic        clk, rst;
  logic        DE_Valid, DE_ALUSrc, DE_RegDst;
  logic [3:0]  DE_ALUCtrl;
  logic [31:0] DE_ReadData1, DE_ReadData2, DE_SignExt, DE_PC4, DE_Instruction;
  logic [4:0]  DE_Rt, DE_Rd;
  logic        DE_MemRead, DE_MemWrite, DE_Branch, DE_MemtoReg, DE_RegWrite;
  logic        Stall;
  logic        EM_MemRead, EM_MemWrite, EM_Branch, EM_MemtoReg, EM_RegWrite, EM_ZERO;
  logic [31:0] EM_Result, EM_Readdata2, EM_BranchTarget, EM_Instruction;
  logic [4:0]  EM_Rd;
  logic [1:0]  dbg_state;
  logic [EM_W-1:0] em_bus;
  logic [EM_W-1:0] exp_q[$];

  int checks   = 0;
  int failures = 0;

  execute_memory #(.DATA_W(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .DE_Valid(DE_Valid), .DE_ALUCtrl(DE_ALUCtrl),
    .DE_ReadData1(DE_ReadData1), .DE_ReadData2(DE_ReadData2),
    .DE_SignExt(DE_SignExt), .DE_ALUSrc(DE_ALUSrc), .DE_RegDst(DE_RegDst),
    .DE_Rt(DE_Rt), .DE_Rd(DE_Rd), .DE_PC4(DE_PC4),
    .DE_MemRead(DE_MemRead), .DE_MemWrite(DE_MemWrite), .DE_Branch(DE_Branch),
    .DE_MemtoReg(DE_MemtoReg), .DE_RegWrite(DE_RegWrite),
    .DE_Instruction(DE_Instruction),
    .Stall(Stall),
    .EM_MemRead(EM_MemRead), .EM_MemWrite(EM_MemWrite), .EM_Branch(EM_Branch),
    .EM_MemtoReg(EM_MemtoReg), .EM_RegWrite(EM_RegWrite), .EM_ZERO(EM_ZERO),
    .EM_Result(EM_Result), .EM_Readdata2(EM_Readdata2), .EM_Rd(EM_Rd),
    .EM_BranchTarget(EM_BranchTarget), .EM_Instruction(EM_Instruction),
    .dbg_state(dbg_state)
  );

  assign em_bus = {EM_MemRead, EM_MemWrite, EM_Branch, EM_MemtoReg, EM_RegWrite, EM_ZERO,
                   EM_Result, EM_Readdata2, EM_Rd, EM_BranchTarget, EM_Instruction};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [EM_W-1:0] expect_em();
    logic [31:0] b, r;
    logic [63:0] p;
    if (!DE_Valid) return '0;
    b = DE_ALUSrc ? DE_SignExt : DE_ReadData2;
    case (DE_ALUCtrl)
      4'd0:  r = DE_ReadData1 & b;
      4'd1:  r = DE_ReadData1 | b;
      4'd2:  r = DE_ReadData1 + b;
      4'd6:  r = DE_ReadData1 - b;
      4'd7:  r = ($signed(DE_ReadData1) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: r = ~(DE_ReadData1 | b);
      4'd8:  begin p = {32'd0, DE_ReadData1} * {32'd0, b}; r = p[31:0]; end
      default: r = 32'd0;
    endcase
    return {DE_MemRead, DE_MemWrite, DE_Branch, DE_MemtoReg, DE_RegWrite, (r == 32'd0),
            r, DE_ReadData2, (DE_RegDst ? DE_Rd : DE_Rt),
            DE_PC4 + DE_SignExt * 32'd4, DE_Instruction};
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_de();
    DE_Valid = 0; DE_ALUCtrl = 0; DE_ReadData1 = 0; DE_ReadData2 = 0; DE_SignExt = 0;
    DE_ALUSrc = 0; DE_RegDst = 0; DE_Rt = 0; DE_Rd = 0; DE_PC4 = 0; DE_Instruction = 0;
    DE_MemRead = 0; DE_MemWrite = 0; DE_Branch = 0; DE_MemtoReg = 0; DE_RegWrite = 0;
  endtask

  task automatic rand_de(input logic [3:0] ctrl, input logic valid);
    DE_Valid = valid; DE_ALUCtrl = ctrl;
    DE_ReadData1 = $urandom; DE_ReadData2 = $urandom; DE_SignExt = $urandom;
    if ($urandom_range(0, 3) == 0) DE_ReadData2 = DE_ReadData1;
    DE_ALUSrc = 1'($urandom_range(0, 1)); DE_RegDst = 1'($urandom_range(0, 1));
    DE_Rt = 5'($urandom); DE_Rd = 5'($urandom);
    DE_PC4 = $urandom; DE_Instruction = $urandom;
    DE_MemRead = 1'($urandom); DE_MemWrite = 1'($urandom); DE_Branch = 1'($urandom);
    DE_MemtoReg = 1'($urandom); DE_RegWrite = 1'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rand_de((i % 2 == 0) ? 4'd8 : 4'($urandom), 1'b1);
      #3;
      checks++;
      if (Stall !== 1'b0 || em_bus !== '0) begin
        failures++;
        $display("FAIL reset_state: Stall=%b em=%h required Stall=0 em=0", Stall, em_bus);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    clear_de();
    DE_Valid = 1; DE_ALUCtrl = 4'd2; DE_ReadData1 = 5; DE_ReadData2 = 7;
    DE_RegDst = 1; DE_Rd = 3; DE_Rt = 9; DE_RegWrite = 1;
    @(posedge clk); #1;
    checks++;
    if (EM_Result !== 32'd12 || EM_Rd !== 5'd3 || EM_RegWrite !== 1'b1) begin
      failures++;
      $display("FAIL reset_add: result=%h rd=%0d rw=%b required 0000000c 3 1",
               EM_Result, EM_Rd, EM_RegWrite);
    end
  endtask

  task automatic test_beq();
    clear_de();
    DE_Valid = 1; DE_ALUCtrl = 4'd6; DE_ReadData1 = 32'h10; DE_ReadData2 = 32'h10;
    DE_Branch = 1; DE_PC4 = 32'h20; DE_SignExt = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    checks++;
    if (EM_ZERO !== 1'b1 || EM_Branch !== 1'b1 || EM_BranchTarget !== 32'h18) begin
      failures++;
      $display("FAIL beq: zero=%b branch=%b target=%h required 1 1 00000018",
               EM_ZERO, EM_Branch, EM_BranchTarget);
    end
  endtask

  task automatic test_lw_sw();
    clear_de();
    DE_Valid = 1; DE_ALUCtrl = 4'd2; DE_ALUSrc = 1; DE_ReadData1 = 32'h40;
    DE_SignExt = 32'd8; DE_MemWrite = 1; DE_ReadData2 = 32'hDEAD;
    @(posedge clk); #1;
    checks++;
    if (EM_Result !== 32'h48 || EM_Readdata2 !== 32'hDEAD || EM_MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL sw_addr: result=%h wdata=%h mw=%b required 00000048 0000dead 1",
               EM_Result, EM_Readdata2, EM_MemWrite);
    end
  endtask

  task automatic test_slt_nor();
    clear_de();
    DE_Valid = 1; DE_ALUCtrl = 4'd7; DE_ReadData1 = 32'hFFFF_FFFF; DE_ReadData2 = 32'd1;
    @(posedge clk); #1;
    checks++;
    if (EM_Result !== 32'd1) begin
      failures++;
      $display("FAIL slt_signed: result=%h required 00000001", EM_Result);
    end
    clear_de();
    DE_Valid = 1; DE_ALUCtrl = 4'd12;
    @(posedge clk); #1;
    checks++;
    if (EM_Result !== 32'hFFFF_FFFF || EM_ZERO !== 1'b0) begin
      failures++;
      $display("FAIL nor: result=%h zero=%b required ffffffff 0", EM_Result, EM_ZERO);
    end
  endtask

  task automatic test_random_alu();
    logic [3:0] codes[7];
    logic [3:0] c;
    logic [EM_W-1:0] exp_v;
    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd0};
    for (int i = 0; i < 80; i++) begin
      c = codes[$urandom_range(0, 6)];
      if (i % 7 == 6) begin
        c = 4'($urandom);
        if (c == 4'd8) c = 4'd9;
      end
      rand_de(c, ($urandom_range(0, 3) != 0));
      exp_q.push_back(expect_em());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (em_bus !== exp_v) begin
        failures++;
        $display("FAIL rand_alu[%0d] op=%0d: em=%h required %h", i, c, em_bus, exp_v);
      end
    end
    clear_de();
  endtask

  // Issues one MUL (called with inputs applied just after an edge) and follows it to
  // completion; returns just after the result edge with DE_Valid dropped.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int stall_cycles, bubble_bad;
    bit done;
    logic [EM_W-1:0] exp_v;
    rand_de(4'd8, 1'b1);
    DE_ReadData1 = a; DE_ReadData2 = b; DE_ALUSrc = 0; DE_RegDst = 1; DE_Rd = rd;
    DE_RegWrite = 1;
    exp_v = expect_em();
    stall_cycles = 0; bubble_bad = 0; done = 0;
    for (int e = 1; e <= 40 && !done; e++) begin
      #3;
      if (Stall === 1'b1) stall_cycles++;
      @(posedge clk); #1;
      if (e < 34 && em_bus !== '0) bubble_bad++;
      if (e == 34) begin
        done = 1;
        checks++;
        if (em_bus !== exp_v) begin
          failures++;
          $display("FAIL mul_result %h*%h: em=%h required %h", a, b, em_bus, exp_v);
        end
      end
    end
    checks++;
    if (stall_cycles != 33) begin
      failures++;
      $display("FAIL mul_stall_len: stall cycles=%0d required 33", stall_cycles);
    end
    checks++;
    if (bubble_bad != 0) begin
      failures++;
      $display("FAIL mul_bubbles: non-bubble edges during stall=%0d required 0", bubble_bad);
    end
    DE_Valid = 0;
  endtask

  task automatic test_mul();
    run_mul(32'd7, 32'd6, 5'd17);
    checks++;
    if (EM_Result !== 32'd42 || EM_Rd !== 5'd17 || EM_RegWrite !== 1'b1) begin
      failures++;
      $display("FAIL mul_7x6: result=%0d rd=%0d rw=%b required 42 17 1",
               EM_Result, EM_Rd, EM_RegWrite);
    end
    run_mul(32'hFFFF_FFFF, 32'd2, 5'd4);
    checks++;
    if (EM_Result !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mul_wrap: result=%h required fffffffe", EM_Result);
    end
  endtask

  task automatic test_back_to_back();
    run_mul($urandom, $urandom, 5'($urandom));
    run_mul($urandom, 32'd0, 5'($urandom));
    run_mul($urandom, $urandom, 5'($urandom));
    #3;
    checks++;
    if (Stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: Stall=%b required 0", Stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    logic [EM_W-1:0] exp_v;
    rand_de(4'd8, 1'b1);
    DE_ALUSrc = 0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0 || em_bus !== '0) begin
      failures++;
      $display("FAIL abort_now: Stall=%b em=%h required 0 0", Stall, em_bus);
    end
    @(posedge clk); #1;
    checks++;
    if (Stall !== 1'b0 || em_bus !== '0) begin
      failures++;
      $display("FAIL abort_held: Stall=%b em=%h required 0 0", Stall, em_bus);
    end
    rand_de(4'd2, 1'b1);
    exp_v = expect_em();
    #2 rst = 1'b1;
    #2;
    checks++;
    if (Stall !== 1'b0) begin
      failures++;
      $display("FAIL abort_release: Stall=%b required 0", Stall);
    end
    @(posedge clk); #1;
    checks++;
    if (em_bus !== exp_v) begin
      failures++;
      $display("FAIL abort_add: em=%h required %h", em_bus, exp_v);
    end
    run_mul($urandom, $urandom, 5'($urandom));
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    clear_de();
    #1;
    test_reset();
    test_beq();
    test_lw_sw();
    test_slt_nor();
    test_random_alu();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_memory.md
Name: execute_memory

Overview:
- EX/MEM stage of the 5-stage MIPS pipeline; sits directly upstream of the memory/writeback stage.
- Takes ID/EX operands and controls, and computes:
  - ALU result / data address
  - branch target and zero flag
  - destination register
- Registers all of these into the EX/MEM pipeline register (EM_*), which the memory stage consumes.
- Includes an iterative 32-cycle shift-add multiplier that stalls upstream while busy.

Parameters:
- DATA_W, 32, datapath width; the multiplier iteration count equals DATA_W.
- MUL_EN, 1, 1 = MUL ALU code supported; 0 = MUL treated as unknown op (result 0, no stall).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- DE_Valid  in  1  ID/EX holds a real instruction; 0 = bubble.
- DE_ALUCtrl  in  4  ALU operation code.
- DE_ReadData1  in  32  rs value (operand A).
- DE_ReadData2  in  32  rt value (operand B / store data).
- DE_SignExt  in  32  sign-extended immediate.
- DE_ALUSrc  in  1  1 = operand B is DE_SignExt.
- DE_RegDst  in  1  1 = destination is DE_Rd, 0 = DE_Rt.
- DE_Rt, DE_Rd  in  5  register specifiers.
- DE_PC4  in  32  PC+4 of the instruction.
- DE_MemRead, DE_MemWrite, DE_Branch, DE_MemtoReg, DE_RegWrite  in  1  control bits.
- DE_Instruction  in  32  instruction word (debug trace).
- Stall  out  1  hold PC, IF/ID and ID/EX.
- EM_MemRead, EM_MemWrite, EM_Branch, EM_MemtoReg, EM_RegWrite  out  1  registered controls.
- EM_ZERO  out  1  registered (ALU result == 0).
- EM_Result  out  32  registered ALU result / memory address.
- EM_Readdata2  out  32  registered store data (= DE_ReadData2).
- EM_Rd  out  5  registered destination register.
- EM_BranchTarget  out  32  registered DE_PC4 + (DE_SignExt << 2), modulo 2^32.
- EM_Instruction  out  32  registered instruction word.

Behaviour:
- Reset (rst=0, asynchronous): every EM_* output is 0; Stall=0; FSM goes to IDLE; multiplier accumulator and counter are cleared.
- Operand B = DE_ALUSrc ? DE_SignExt : DE_ReadData2.
- ALU codes (any other code gives result 0):
  - 0000 AND, 0001 OR, 0010 ADD (wraps), 0110 SUB (wraps)
  - 0111 SLT: signed compare, result 1 or 0
  - 1100 NOR
  - 1000 MUL: low 32 bits of the unsigned product
- Non-MUL ops, latency 1: the EM register captures results at the next edge.
- FSM states: IDLE, MUL_BUSY, MUL_DONE.
- IDLE, with DE_Valid=1 and MUL (MUL_EN=1):
  - Stall=1 combinationally in the same cycle.
  - Latch A as multiplicand and B as multiplier; clear accumulator and counter.
  - EM register loads a bubble; go to MUL_BUSY.
- MUL_BUSY, each cycle:
  - If multiplier[0], acc += multiplicand.
  - multiplicand <<= 1, multiplier >>= 1, count++.
  - Stall=1; EM register loads a bubble.
  - After DATA_W iterations (count == DATA_W-1 step), go to MUL_DONE.
- MUL_DONE:
  - Stall=0.
  - At this edge the EM register captures the product plus the still-held DE_* controls and Rd; then go to IDLE.
- MUL timing: Stall is high for DATA_W+1 cycles. The result appears on EM_Result DATA_W+2 edges after issue.
- Bubble: all EM control bits 0; EM_Result, EM_Rd, EM_Instruction, EM_BranchTarget, EM_Readdata2 and EM_ZERO all 0.
- DE_Valid=0 in IDLE: bubble, no stall.
- Upstream must keep DE_* constant while Stall=1; the stage samples them again in MUL_DONE.
- EM_ZERO is evaluated on the final result, including MUL.
- Reset asserted mid-multiply:
  - Immediate abort; FSM to IDLE and Stall=0.
  - No partial product is ever written to the EM register.
- Back-to-back MULs: the second is issued from IDLE the cycle after MUL_DONE. There is no overlap.

Test Plan:
- Reset: rst=0 with random DE_* inputs -> all EM_* = 0, Stall=0. Release rst and apply ADD 5+7, RegDst=1, Rd=3 -> next edge EM_Result=12, EM_Rd=3, EM_RegWrite passes through.
- BEQ: SUB, A=B=0x10, Branch=1, PC4=0x20, SignExt=0xFFFFFFFE -> EM_ZERO=1, EM_Branch=1, EM_BranchTarget=0x18.
- LW/SW: ALUSrc=1, A=0x40, SignExt=8, ADD, MemWrite=1, ReadData2=0xDEAD -> EM_Result=0x48, EM_Readdata2=0xDEAD, EM_MemWrite=1.
- SLT signed: A=0xFFFFFFFF, B=1 -> EM_Result=1. NOR of 0 and 0 -> 0xFFFFFFFF, EM_ZERO=0.
- MUL 7*6:
  - Stall high for exactly 33 cycles; bubbles in EM during the stall.
  - At edge 34 after issue, EM_Result=42 with the op's Rd and RegWrite.
- MUL 0xFFFFFFFF*2 -> EM_Result=0xFFFFFFFE. Then drop rst to 0 at iteration 10 of a second MUL -> Stall=0, EM bubble; after release, ADD executes normally.
